// File: rtl/mem_wb_stage.sv
// MEM/WB stage: performs the data-memory access of an executed bundle and
// produces the register-file writeback, stalling upstream across memory latency.
module mem_wb_stage #(
    parameter int XLEN      = 64,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mem_rd,
    input  logic                 in_mem_wr,
    input  logic                 in_mem_to_reg,
    input  logic                 in_rf_wr,
    input  logic [RF_ADDR_W-1:0] in_rf_wr_addr,
    input  logic [XLEN-1:0]      in_alu_res,
    input  logic [XLEN-1:0]      in_store_data,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_en,
    output logic [RF_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]      wb_data,
    output logic                 err_rdwr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_req;
    logic                  r_we;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_wb_en;
    logic [RF_ADDR_W-1:0]  r_wb_addr;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_err;
    logic                  r_rf_wr;
    logic                  r_m2r;
    logic [RF_ADDR_W-1:0]  r_rd_addr;
    logic [XLEN-1:0]       r_alu;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_wb_fire;
    logic                  w_wb_rf;
    logic [RF_ADDR_W-1:0]  w_wb_addr_nxt;
    logic [XLEN-1:0]       w_wb_data_nxt;
    logic                  w_wb_en_nxt;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_is_mem = in_mem_rd | in_mem_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the writeback that completes in this cycle, if any.
    always_comb begin
        w_state_nxt   = r_state;
        w_wb_fire     = 1'b0;
        w_wb_rf       = 1'b0;
        w_wb_addr_nxt = r_rd_addr;
        w_wb_data_nxt = r_alu;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_wb_fire     = 1'b1;
                        w_wb_rf       = in_rf_wr;
                        w_wb_addr_nxt = in_rf_wr_addr;
                        w_wb_data_nxt = in_alu_res;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (r_we) begin
                        w_state_nxt = IDLE;
                        w_wb_fire   = 1'b1;
                        w_wb_rf     = r_rf_wr;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    w_state_nxt   = IDLE;
                    w_wb_fire     = 1'b1;
                    w_wb_rf       = r_rf_wr;
                    w_wb_data_nxt = r_m2r ? dmem_rdata : r_alu;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_wb_en_nxt = w_wb_fire & w_wb_rf & (w_wb_addr_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_err     <= 1'b0;
            r_rf_wr   <= 1'b0;
            r_m2r     <= 1'b0;
            r_rd_addr <= '0;
            r_alu     <= '0;
        end else begin
            r_wb_en <= w_wb_en_nxt;
            r_err   <= w_accept & in_mem_rd & in_mem_wr;
            // wb_addr/wb_data only move on a real rf write so they hold otherwise.
            if (w_wb_en_nxt) begin
                r_wb_addr <= w_wb_addr_nxt;
                r_wb_data <= w_wb_data_nxt;
            end
            if (w_accept && w_is_mem) begin
                r_req     <= 1'b1;
                r_we      <= in_mem_wr;
                r_addr    <= in_alu_res;
                r_wdata   <= in_store_data;
                r_rf_wr   <= in_rf_wr;
                r_m2r     <= in_mem_to_reg;
                r_rd_addr <= in_rf_wr_addr;
                r_alu     <= in_alu_res;
            end else if (r_state == REQ && dmem_gnt) begin
                r_req <= 1'b0;
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_en      = r_wb_en;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign err_rdwr   = r_err;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the ID->EX->MEM->WB pipeline bundle: accepts one executed instruction per handshake and performs its data-memory access, if any.
- Produces the register-file writeback: rf write enable, address and data.
- Sits between the EX pipeline register and the register file.
- Handles memory grant/response latency with a small FSM; ALU-only ops flow at one per cycle.

Parameters:
- XLEN, 64, data/address width (matches the 64-bit pipeline datapath)
- RF_ADDR_W, 5, register-file write address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bundle from EX is valid
- in_ready  out  1  stage can accept bundle; combinational, =1 iff state==IDLE
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_mem_to_reg  in  1  writeback selects load data (else ALU result)
- in_rf_wr  in  1  instruction writes rf
- in_rf_wr_addr  in  RF_ADDR_W  destination register
- in_alu_res  in  XLEN  ALU result / memory address
- in_store_data  in  XLEN  store data (rs2)
- dmem_req  out  1  memory request, held until granted
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  XLEN  request address
- dmem_wdata  out  XLEN  store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data
- wb_en  out  1  rf write strobe, one-cycle pulse
- wb_addr  out  RF_ADDR_W  rf write address
- wb_data  out  XLEN  rf write data
- err_rdwr  out  1  one-cycle pulse: bundle had mem_rd and mem_wr both set

Behaviour:
- Reset (rst_n low, async): state=IDLE; dmem_req, dmem_we, wb_en, err_rdwr=0; dmem_addr, dmem_wdata, wb_addr, wb_data=0; captured bundle cleared. in_valid is ignored while rst_n is low. Reset asserted mid-transaction abandons it; a pending grant or response is ignored after release.
- Accept: in_valid & in_ready on cycle N captures all in_* fields.
- ALU-only bundle (mem_rd=mem_wr=0): wb pulse on N+1; state stays IDLE, so back-to-back accepts give one writeback per cycle.
- Memory bundle: state->REQ at N+1 with dmem_req=1 and dmem_addr=in_alu_res, dmem_we=in_mem_wr, dmem_wdata=in_store_data. All request outputs stay stable until dmem_gnt.
- REQ, cycle G with dmem_gnt=1: dmem_req drops at G+1.
  - Store: ->IDLE at G+1; wb pulse at G+1 only if rf_wr (data=alu_res).
  - Load: ->WAIT.
- WAIT: dmem_rvalid sampled from G+1 onward. On rvalid at R, rdata is captured; wb pulse at R+1; ->IDLE at R+1.
- dmem_rvalid in IDLE/REQ is ignored. dmem_gnt outside REQ is ignored.
- wb_data = mem_to_reg ? load data : alu_res. mem_to_reg=1 without mem_rd uses alu_res.
- wb_en = rf_wr & (wb_addr!=0); x0 is never written. wb_addr and wb_data are registered and hold their last value when wb_en=0.
- mem_rd & mem_wr both set: treated as store (mem_wr priority); err_rdwr pulses on N+1.
- Unbounded wait for gnt/rvalid: no timeout; in_ready stays 0.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random inputs -> all outputs 0, no wb; release -> in_ready=1 and first accept works.
- Back-to-back ALU: 3 accepts on cycles 1,2,3 (rd x5=0x11, x6=0x22, x0=0x33) -> wb_en on 2,3 with (5,0x11),(6,0x22); cycle 4 wb_en=0 for x0.
- Load, gnt delayed 2 cycles, rvalid 3 cycles after gnt: addr 0x1000, rdata 0xDEADBEEF, rd x10, mem_to_reg=1 -> dmem_req stable until gnt; wb (10,0xDEADBEEF) one cycle after rvalid; in_ready=0 throughout, then 1.
- Store with immediate gnt: addr 0x2008, data 0xCAFE, rf_wr=0 -> dmem_we=1, dmem_wdata=0xCAFE; no wb; in_ready=1 the cycle after gnt.
- Spurious responses: rvalid pulsed in IDLE and in REQ, gnt pulsed in IDLE -> no state change, no wb; err_rdwr: bundle with rd=wr=1 -> store issued, err_rdwr=1 for exactly one cycle.
- Reset mid-load while in WAIT -> state IDLE, dmem_req=0; a late rvalid after release produces no wb.
